// File: rtl/bcd_to_bin_seq.sv
// bcd_to_bin_seq: sequential BCD-to-binary converter (reverse double-dabble).
// Each CONV cycle shifts the {digits, binary} register right by one bit.
// After the shift, 3 is subtracted from every digit that is >= 8.
// A result is ready after BIN_W steps and is announced by a one-cycle valid pulse.
// Optional feature: define BCD_TO_BIN_CHECK_EN to reject requests that
// contain a nibble > 9. Such a request finishes with err=1 and bin=0.
module bcd_to_bin_seq #(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned BIN_W  = 14
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd,
  output logic                  busy,
  output logic                  valid,
  output logic [BIN_W-1:0]      bin,
  output logic                  err
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned SR_W  = BCD_W + BIN_W;
  localparam int unsigned CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(BIN_W - 1);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t            state, state_n;
  logic [SR_W-1:0]   sr, sr_n, t_adj;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic              busy_n, valid_n;
  logic [BIN_W-1:0]  bin_n;

`ifdef BCD_TO_BIN_CHECK_EN
  logic err_q, err_n;
  logic abort_pend, abort_pend_n;
  logic bad_digit;

  // Flag any nibble of the incoming request that is not a decimal digit.
  always_comb begin
    bad_digit = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] > 4'd9) bad_digit = 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // One conversion step: shift right, then correct every digit that is >= 8.
  always_comb begin
    t_adj = sr >> 1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (t_adj[BIN_W + 4*i +: 4] >= 4'd8)
        t_adj[BIN_W + 4*i +: 4] = t_adj[BIN_W + 4*i +: 4] - 4'd3;
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_n = state;
    sr_n    = sr;
    cnt_n   = cnt;
    busy_n  = busy;
    valid_n = 1'b0;
    bin_n   = bin;
`ifdef BCD_TO_BIN_CHECK_EN
    err_n        = err_q;
    abort_pend_n = abort_pend;
`endif
    case (state)
      IDLE, DONE: begin
`ifdef BCD_TO_BIN_CHECK_EN
        // A rejected request spends one busy cycle in DONE before it reports.
        // This gives valid one cycle after start, and start is ignored meanwhile.
        if (abort_pend) begin
          bin_n        = '0;
          err_n        = 1'b1;
          valid_n      = 1'b1;
          busy_n       = 1'b0;
          abort_pend_n = 1'b0;
          state_n      = DONE;
        end else
`endif
        if (start) begin
          sr_n   = {bcd, {BIN_W{1'b0}}};
          cnt_n  = '0;
          busy_n = 1'b1;
          state_n = CONV;
`ifdef BCD_TO_BIN_CHECK_EN
          if (bad_digit) begin
            state_n      = DONE;
            abort_pend_n = 1'b1;
          end
`endif
        end else begin
          state_n = IDLE;
        end
      end
      CONV: begin
        sr_n  = t_adj;
        cnt_n = cnt + 1'b1;
        if (cnt == LAST_STEP) begin
          bin_n   = t_adj[BIN_W-1:0];
          valid_n = 1'b1;
          busy_n  = 1'b0;
          state_n = DONE;
`ifdef BCD_TO_BIN_CHECK_EN
          err_n   = 1'b0;
`endif
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      sr    <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      valid <= 1'b0;
      bin   <= '0;
`ifdef BCD_TO_BIN_CHECK_EN
      err_q      <= 1'b0;
      abort_pend <= 1'b0;
`endif
    end else begin
      state <= state_n;
      sr    <= sr_n;
      cnt   <= cnt_n;
      busy  <= busy_n;
      valid <= valid_n;
      bin   <= bin_n;
`ifdef BCD_TO_BIN_CHECK_EN
      err_q      <= err_n;
      abort_pend <= abort_pend_n;
`endif
    end
  end

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// tb_bcd_to_bin_seq: directed self-checking bench for bcd_to_bin_seq.
// It exercises the digit-check path when BCD_TO_BIN_CHECK_EN is defined.
module tb_bcd_to_bin_seq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [15:0] bcd;
  logic        busy;
  logic        valid;
  logic [13:0] bin;
  logic        err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  bcd_to_bin_seq #(.DIGITS(4), .BIN_W(14)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .bcd     (bcd),
    .busy    (busy),
    .valid   (valid),
    .bin     (bin),
    .err     (err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one request from a negedge and follow it for lat+4 cycles.
  task automatic conv(input string tag, input logic [15:0] b, input logic [13:0] exp_bin,
                      input logic exp_err, input int lat);
    int busy_cnt = 0;
    int vcnt = 0;
    int vk = -1;
    start = 1'b1;
    bcd   = b;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 0; k < lat + 4; k++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (valid) begin
        vcnt++;
        if (vk < 0) begin
          vk = k;
          check({tag, "_bin"}, 32'(bin), 32'(exp_bin));
          check({tag, "_err"}, 32'(err), 32'(exp_err));
        end
      end
    end
    check({tag, "_latency"}, 32'(vk), 32'(lat));
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(lat));
    check({tag, "_valid_pulses"}, 32'(vcnt), 32'd1);
  endtask

  initial begin
    int v1, v2, vk, vcnt;

    reset_n = 1'b0;
    start   = 1'b0;
    bcd     = '0;
    #12;
    check("rst_busy",  32'(busy),  32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_bin",   32'(bin),   32'd0);
    check("rst_err",   32'(err),   32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    conv("zero", 16'h0000, 14'd0,    1'b0, 14);
    conv("n9999", 16'h9999, 14'h270F, 1'b0, 14);
    conv("n1234", 16'h1234, 14'h04D2, 1'b0, 14);
    conv("n0001", 16'h0001, 14'd1,    1'b0, 14);

    // Back-to-back: start stays high and the next operand is presented on the DONE cycle.
    v1 = -1; v2 = -1; vcnt = 0;
    start = 1'b1;
    bcd   = 16'h0042;
    @(posedge clk);
    #1;
    for (int k = 0; k < 45; k++) begin
      @(negedge clk);
      if (v1 >= 0 && k == v1 + 1) start = 1'b0;
      if (valid) begin
        vcnt++;
        if (v1 < 0) begin
          v1 = k;
          check("b2b_bin1", 32'(bin), 32'd42);
          bcd = 16'h0100;
        end else if (v2 < 0) begin
          v2 = k;
          check("b2b_bin2", 32'(bin), 32'd100);
        end
      end
    end
    start = 1'b0;
    check("b2b_first_latency", 32'(v1), 32'd14);
    check("b2b_spacing", 32'(v2 - v1), 32'd15);
    check("b2b_valid_pulses", 32'(vcnt), 32'd2);

    // A start pulse during CONV must be ignored.
    vk = -1; vcnt = 0;
    start = 1'b1;
    bcd   = 16'h1234;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 0; k < 35; k++) begin
      @(negedge clk);
      if (k == 5) begin
        start = 1'b1;
        bcd   = 16'h9999;
      end
      if (k == 6) start = 1'b0;
      if (valid) begin
        vcnt++;
        if (vk < 0) begin
          vk = k;
          check("ign_bin", 32'(bin), 32'h04D2);
        end
      end
    end
    check("ign_latency", 32'(vk), 32'd14);
    check("ign_valid_pulses", 32'(vcnt), 32'd1);

    // Asynchronous reset in the middle of a conversion.
    start = 1'b1;
    bcd   = 16'h5555;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 0; k < 8; k++) @(negedge clk);
    check("mid_busy_before", 32'(busy), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("mid_busy",  32'(busy),  32'd0);
    check("mid_valid", 32'(valid), 32'd0);
    check("mid_bin",   32'(bin),   32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    vcnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (valid) vcnt++;
    end
    check("mid_no_valid", 32'(vcnt), 32'd0);
    conv("n0007", 16'h0007, 14'd7, 1'b0, 14);

`ifdef BCD_TO_BIN_CHECK_EN
    conv("bad12A4", 16'h12A4, 14'd0,  1'b1, 1);
    conv("n0012",   16'h0012, 14'd12, 1'b0, 14);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
